qcnt: RTL and testbench

- Transaction-statistics stage placed directly downstream of the eot-projecting stage.
- Consumes a queue stream on the `din` dti interface: `TDIN` data bits plus `DIN_LVL` eot bits.
- For each complete outermost transaction, emits one word on the `dout` dti interface:
  - number of elements,
  - number of innermost sub-transactions,
  - a sticky saturation flag.
- Used for length checking and for header generation ahead of serializers.

---
 rtl/qcnt_pkg.sv | 37 +++
 rtl/qcnt_if.sv | 20 ++
 rtl/qcnt_sat_inc.sv | 28 ++
 rtl/qcnt.sv | 149 ++++++++++++++
 tb/tb_qcnt.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qcnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qcnt_pkg
//  Description : Shared types and helpers for the qcnt transaction-statistics
//                stage (result word layout, output-register state, last-eot
//                detection).
//  Revision    : 1.0 - initial release
// ============================================================================
package qcnt_pkg;

  // Widest eot field the last-detection helper accepts.
  localparam int QCNT_MAX_LVL = 8;

  // Counter width of the default result word.
  localparam int QCNT_CNT_W = 16;

  // Result word at the default counter width: elem_cnt in the LSBs.
  typedef struct packed {
    logic                  ovf;
    logic [QCNT_CNT_W-1:0] sub_cnt;
    logic [QCNT_CNT_W-1:0] elem_cnt;
  } qcnt_dout_t;

  // Output register occupancy; FULL is exactly "dout.valid".
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Outermost end-of-transaction: every eot bit set. Callers pad the unused
  // upper bits with ones so that only the real eot bits decide.
  function automatic logic is_last(input logic [QCNT_MAX_LVL-1:0] eot_padded);
    return &eot_padded;
  endfunction

endpackage : qcnt_pkg
`default_nettype wire

// File: rtl/qcnt_if.sv
`default_nettype none
// ============================================================================
//  Module      : qcnt_if
//  Description : Valid/ready (dti) stream interface with a parameterised data
//                width. The master drives data/valid, the slave drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qcnt_if #(
  parameter int W = 18
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface : qcnt_if
`default_nettype wire

// File: rtl/qcnt_sat_inc.sv
`default_nettype none
// ============================================================================
//  Module      : qcnt_sat_inc
//  Description : Combinational saturating incrementer. Adds a single-bit
//                increment to a counter value, holding at all-ones and
//                flagging the increment that could not be applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module qcnt_sat_inc #(
  parameter int W = 16
) (
  input  wire logic [W-1:0] i_value,
  input  wire logic         i_inc,
  output logic      [W-1:0] o_sum,
  output logic              o_ovf
);

  logic w_at_max;

  // An increment on an all-ones value is the only way to exceed the maximum.
  always_comb begin
    w_at_max = &i_value;
    o_ovf    = i_inc & w_at_max;
    o_sum    = o_ovf ? i_value : (i_value + W'(i_inc));
  end

endmodule : qcnt_sat_inc
`default_nettype wire

// File: rtl/qcnt.sv
`default_nettype none
// ============================================================================
//  Module      : qcnt
//  Description : Transaction-statistics stage. Counts elements and innermost
//                sub-transactions of each outermost transaction on din and
//                emits one {ovf, sub_cnt, elem_cnt} word per transaction on
//                dout, one cycle after the last element's handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module qcnt
  import qcnt_pkg::*;
#(
  parameter int TDIN    = 16,  // payload width, carried only for framing
  parameter int DIN_LVL = 2,   // eot bits on din, 1..QCNT_MAX_LVL
  parameter int CNT_W   = 16   // width of each counter field
) (
  input  wire logic clk,
  input  wire logic rst_n,
  qcnt_if.slave     din,
  qcnt_if.master    dout
);

  // Result word at this instance's counter width; same layout as qcnt_dout_t.
  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] sub_cnt;
    logic [CNT_W-1:0] elem_cnt;
  } dout_t;

  logic [DIN_LVL-1:0]      w_eot;
  logic [QCNT_MAX_LVL-1:0] w_eot_pad;
  logic                    w_last;
  logic                    w_sub_end;
  logic                    w_hs_in;
  logic                    w_hs_out;
  logic                    w_last_hs;

  logic [CNT_W-1:0]        r_acc_elem;
  logic [CNT_W-1:0]        r_acc_sub;
  logic                    r_acc_ovf;

  logic [CNT_W-1:0]        w_elem_sum;
  logic [CNT_W-1:0]        w_sub_sum;
  logic                    w_elem_ovf;
  logic                    w_sub_ovf;

  out_state_t              r_state;
  out_state_t              w_state_nxt;
  dout_t                   r_out_data;
  dout_t                   w_result;

  assign w_eot     = din.data[TDIN +: DIN_LVL];
  assign w_sub_end = w_eot[0];

  // Pad unused eot positions with ones so only the real eot bits decide "last".
  generate
    if (DIN_LVL < QCNT_MAX_LVL) begin : g_eot_pad
      assign w_eot_pad = {{(QCNT_MAX_LVL - DIN_LVL){1'b1}}, w_eot};
    end else begin : g_eot_full
      assign w_eot_pad = w_eot[QCNT_MAX_LVL-1:0];
    end
  endgenerate

  assign w_last = is_last(w_eot_pad);

  // Non-last elements never stall; the last one waits only on an unconsumed
  // result. A draining result frees the register in the same cycle.
  assign din.ready = !w_last || (r_state == OUT_EMPTY) || dout.ready;

  assign w_hs_in   = din.valid & din.ready;
  assign w_hs_out  = dout.valid & dout.ready;
  assign w_last_hs = w_hs_in & w_last;

  qcnt_sat_inc #(.W(CNT_W)) u_elem_inc (
    .i_value (r_acc_elem),
    .i_inc   (1'b1),
    .o_sum   (w_elem_sum),
    .o_ovf   (w_elem_ovf)
  );

  // The last element has every eot bit set, so eot[0] already counts its
  // closing sub-transaction.
  qcnt_sat_inc #(.W(CNT_W)) u_sub_inc (
    .i_value (r_acc_sub),
    .i_inc   (w_sub_end),
    .o_sum   (w_sub_sum),
    .o_ovf   (w_sub_ovf)
  );

  // Result word formed from the accumulators plus the last element's increments.
  always_comb begin
    w_result          = '0;
    w_result.ovf      = r_acc_ovf | w_elem_ovf | w_sub_ovf;
    w_result.sub_cnt  = w_sub_sum;
    w_result.elem_cnt = w_elem_sum;
  end

  // Accumulate per accepted element; clear when the transaction closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_elem <= '0;
      r_acc_sub  <= '0;
      r_acc_ovf  <= 1'b0;
    end else if (w_hs_in) begin
      if (w_last) begin
        r_acc_elem <= '0;
        r_acc_sub  <= '0;
        r_acc_ovf  <= 1'b0;
      end else begin
        r_acc_elem <= w_elem_sum;
        r_acc_sub  <= w_sub_sum;
        r_acc_ovf  <= r_acc_ovf | w_elem_ovf | w_sub_ovf;
      end
    end
  end

  // Output register occupancy: a new result wins over a simultaneous drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_last_hs) w_state_nxt = OUT_FULL;
      OUT_FULL:  if (!w_last_hs && w_hs_out) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result data only loads on a last handshake, so it is stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (w_last_hs) begin
      r_out_data <= w_result;
    end
  end

  assign dout.valid = (r_state == OUT_FULL);
  assign dout.data  = r_out_data;

endmodule : qcnt
`default_nettype wire

// File: tb/tb_qcnt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qcnt
//  Description : Scoreboard testbench for qcnt (TDIN=16, DIN_LVL=2, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qcnt;

  localparam int TDIN    = 16;
  localparam int DIN_LVL = 2;
  localparam int CNT_W   = 4;
  localparam int DW      = 2 * CNT_W + 1;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  qcnt_if #(.W(TDIN + DIN_LVL)) din_if ();
  qcnt_if #(.W(DW))             dout_if ();

  qcnt #(.TDIN(TDIN), .DIN_LVL(DIN_LVL), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din_if),
    .dout  (dout_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              checks;
  int              errors;
  logic [DW-1:0]   exp_q[$];
  int              m_elem;
  int              m_sub;
  bit              m_ovf;
  bit              use_model;
  bit              rand_mode;
  bit              hold_prev;
  logic [DW-1:0]   prev_data;
  int              w;

  function automatic logic [DW-1:0] mk(input bit ovf, input int sub, input int elem);
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] e;
    s = sub[CNT_W-1:0];
    e = elem[CNT_W-1:0];
    return {ovf, s, e};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference counting model, applied at every accepted element.
  task automatic model_accept(input logic [1:0] eot);
    int  e;
    int  s;
    bit  o;
    e = m_elem + 1;
    s = m_sub + (eot[0] ? 1 : 0);
    o = m_ovf;
    if (e > MAXC) begin e = MAXC; o = 1'b1; end
    if (s > MAXC) begin s = MAXC; o = 1'b1; end
    if (eot == 2'b11) begin
      if (use_model) exp_q.push_back(mk(o, s, e));
      m_elem = 0; m_sub = 0; m_ovf = 1'b0;
    end else begin
      m_elem = e; m_sub = s; m_ovf = o;
    end
  endtask

  task automatic drive(input logic [1:0] eot);
    din_if.valid = 1'b1;
    din_if.data  = {eot, 16'($urandom)};
  endtask

  // Waits for the presented element to be accepted; waits = stalled cycles.
  task automatic wait_accept(input logic [1:0] eot, output int waits);
    bit ok;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = din_if.ready;
      @(posedge clk);
      #1;
      if (rand_mode) dout_if.ready = 1'($urandom_range(0, 1));
      if (ok) break;
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no handshake required one within 200 cycles");
        break;
      end
    end
    if (ok) model_accept(eot);
    din_if.valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] eot, output int waits);
    drive(eot);
    wait_accept(eot, waits);
  endtask

  task automatic idle(input int n);
    din_if.valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_mode) dout_if.ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Pops and compares every delivered result; also checks held-result stability.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 32'(dout_if.valid), 32'd1);
          check("hold_data", 32'(dout_if.data), 32'(prev_data));
        end
        if (dout_if.valid && dout_if.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h required no output", dout_if.data);
          end else begin
            check("result", 32'(dout_if.data), 32'(exp_q.pop_front()));
          end
        end
        hold_prev = dout_if.valid & !dout_if.ready;
        prev_data = dout_if.data;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_elem = 0; m_sub = 0; m_ovf = 1'b0;
    use_model = 1'b0; rand_mode = 1'b0; hold_prev = 1'b0; prev_data = '0;
    rst_n = 1'b0;
    din_if.valid = 1'b0;
    din_if.data  = '0;
    dout_if.ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", 32'(dout_if.valid), 32'd0);
    check("rst_dout_data", 32'(dout_if.data), 32'd0);
    check("rst_din_ready", 32'(din_if.ready), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Basic transaction: eots 00,01,00,11 -> {0,2,4}, valid one cycle later
    dout_if.ready = 1'b1;
    exp_q.push_back(mk(1'b0, 2, 4));
    send(2'b00, w);
    send(2'b01, w);
    send(2'b00, w);
    send(2'b11, w);
    check("t1_latency_valid", 32'(dout_if.valid), 32'd1);
    idle(3);

    // Back-to-back single-element transactions at full throughput
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1'b0, 1, 1));
      send(2'b11, w);
      check("t2_no_stall", 32'(w), 32'd0);
      check("t2_valid", 32'(dout_if.valid), 32'd1);
    end
    idle(3);

    // Held result: non-last accepted, last stalls until drain
    dout_if.ready = 1'b0;
    exp_q.push_back(mk(1'b0, 1, 1));
    send(2'b11, w);
    exp_q.push_back(mk(1'b0, 2, 4));
    send(2'b00, w);
    check("t3_nonlast0", 32'(w), 32'd0);
    send(2'b01, w);
    check("t3_nonlast1", 32'(w), 32'd0);
    send(2'b00, w);
    check("t3_nonlast2", 32'(w), 32'd0);
    drive(2'b11);
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_ready", 32'(din_if.ready), 32'd0);
      @(posedge clk);
      #1;
    end
    dout_if.ready = 1'b1;
    wait_accept(2'b11, w);
    check("t3_last_accept", 32'(w), 32'd0);
    check("t3_valid_reload", 32'(dout_if.valid), 32'd1);
    idle(3);

    // Saturation: 20 elements all ending a sub-transaction, then {0,1,2}
    exp_q.push_back(mk(1'b1, 15, 15));
    exp_q.push_back(mk(1'b0, 1, 2));
    for (int i = 0; i < 19; i++) send(2'b01, w);
    send(2'b11, w);
    send(2'b00, w);
    send(2'b11, w);
    idle(3);

    // Reset mid-transaction (with an undelivered result held) discards all
    dout_if.ready = 1'b0;
    send(2'b11, w);
    for (int i = 0; i < 5; i++) send((i % 2) ? 2'b01 : 2'b00, w);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(dout_if.valid), 32'd0);
    check("t5_async_data", 32'(dout_if.data), 32'd0);
    m_elem = 0; m_sub = 0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_if.ready = 1'b1;
    exp_q.push_back(mk(1'b0, 1, 2));
    send(2'b00, w);
    send(2'b11, w);
    idle(3);

    // Random lengths, random eots, random valid gaps and ready toggling
    use_model = 1'b1;
    rand_mode = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len - 1; k++) begin
        send(2'($urandom_range(0, 2)), w);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      send(2'b11, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_mode = 1'b0;
    dout_if.ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) idle(1);
    idle(2);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_qcnt
`default_nettype wire
